// File: rtl/pen_line_draw.sv
// pen_line_draw
//   Takes pen positions from the camera tracker and turns them into a
//   continuous stroke. For each position drawn with the pen down, it emits every
//   pixel on the straight line from the previous position to the new one, using
//   Bresenham's line algorithm. Pixels go out one per handshake, so the
//   downstream pixel buffer write path can apply backpressure.
//
// Ports
//   clk        single clock (vga_clk domain)
//   reset      synchronous, active-low
//   pen_valid  a new pen sample is present
//   pen_ready  the block accepts a sample; high only while IDLE
//   pen_x/y    sample coordinates; a value past X_MAX/Y_MAX means the pen is not visible
//   pen_down   1 = draw from the last point to this one, 0 = move only
//   pix_valid  a pixel is presented on pix_x/pix_y
//   pix_ready  downstream accepts the presented pixel
//   pix_x/y    pixel coordinates; held stable while stalled
//   busy       a segment is being set up or drawn
//
// State table
//   IDLE   | waiting for a pen sample; pen_ready=1
//   SETUP  | one cycle to compute the deltas, the step directions and the initial error
//   DRAW   | presenting the current pixel and stepping on each accepted pixel
module pen_line_draw #(
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pen_valid,
    output logic          pen_ready,
    input  logic [XW-1:0] pen_x,
    input  logic [YW-1:0] pen_y,
    input  logic          pen_down,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          busy
);

    // Two guard bits: one for the sign, and one so that |delta| always fits.
    localparam int CW = ((XW > YW) ? XW : YW) + 2;
    localparam logic signed [CW-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t               state;
    logic                 have_last;
    logic [XW-1:0]        last_x, end_x;
    logic [YW-1:0]        last_y, end_y;
    logic signed [CW-1:0] dx, dy, err;
    logic                 step_x_neg, step_y_neg;

    logic                 pen_fire, pix_fire, in_range, at_end;
    logic signed [CW-1:0] diff_x, diff_y, abs_dx, abs_dy, err_next;
    logic signed [CW:0]   e2, dx_w, dy_w;
    logic                 move_x, move_y;

    always_comb begin
        pen_fire = pen_valid && pen_ready;
        pix_fire = pix_valid && pix_ready;
        in_range = (pen_x <= XW'(X_MAX)) && (pen_y <= YW'(Y_MAX));
        at_end   = (pix_x == end_x) && (pix_y == end_y);

        // pix_x/pix_y hold the current point, which is the segment start during SETUP.
        diff_x = signed'(CW'(end_x)) - signed'(CW'(pix_x));
        diff_y = signed'(CW'(end_y)) - signed'(CW'(pix_y));
        abs_dx = diff_x[CW-1] ? -diff_x : diff_x;
        abs_dy = diff_y[CW-1] ? -diff_y : diff_y;

        // e2 = 2*err needs one more bit. Both step decisions use the old error.
        e2       = {err, 1'b0};
        dx_w     = {dx[CW-1], dx};
        dy_w     = {dy[CW-1], dy};
        move_x   = (e2 >= dy_w);
        move_y   = (e2 <= dx_w);
        err_next = err + (move_x ? dy : ZERO) + (move_y ? dx : ZERO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pen_ready  <= 1'b1;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            busy       <= 1'b0;
            have_last  <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
            end_x      <= '0;
            end_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            step_x_neg <= 1'b0;
            step_y_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pen_fire) begin
                        if (!in_range) begin
                            have_last <= 1'b0;
                        end else if (!pen_down || !have_last) begin
                            last_x    <= pen_x;
                            last_y    <= pen_y;
                            have_last <= 1'b1;
                        end else begin
                            end_x     <= pen_x;
                            end_y     <= pen_y;
                            pix_x     <= last_x;
                            pix_y     <= last_y;
                            state     <= SETUP;
                            pen_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    dx         <= abs_dx;
                    dy         <= -abs_dy;
                    err        <= abs_dx - abs_dy;
                    step_x_neg <= diff_x[CW-1];
                    step_y_neg <= diff_y[CW-1];
                    pix_valid  <= 1'b1;
                    state      <= DRAW;
                end
                DRAW: begin
                    if (pix_fire) begin
                        if (at_end) begin
                            last_x    <= end_x;
                            last_y    <= end_y;
                            pix_valid <= 1'b0;
                            pen_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            err <= err_next;
                            if (move_x)
                                pix_x <= step_x_neg ? pix_x - XW'(1) : pix_x + XW'(1);
                            if (move_y)
                                pix_y <= step_y_neg ? pix_y - YW'(1) : pix_y + YW'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pen_ready <= 1'b1;
                    pix_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pen_line_draw.sv
// tb_pen_line_draw
//   Self-checking bench for pen_line_draw. The scenario tasks queue the pixels
//   they expect. A negedge monitor pops one entry for each pixel handshake and
//   compares it against the pixel on the outputs. Each task also checks
//   handshake timing, stall behaviour and reset state on its own.
module tb_pen_line_draw;

    logic       clk;
    logic       reset;
    logic       pen_valid;
    logic       pen_ready;
    logic [9:0] pen_x;
    logic [9:0] pen_y;
    logic       pen_down;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];
    int model_x = 0;
    int model_y = 0;

    pen_line_draw #(.XW(10), .YW(10), .X_MAX(639), .Y_MAX(479)) dut (
        .clk       (clk),
        .reset     (reset),
        .pen_valid (pen_valid),
        .pen_ready (pen_ready),
        .pen_x     (pen_x),
        .pen_y     (pen_y),
        .pen_down  (pen_down),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: each accepted pixel must be the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pix_unexpected got=(%0d,%0d) required=none", pix_x, pix_y);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({pix_x, pix_y} !== e) begin
                    bad++;
                    $display("FAIL pix_value got=(%0d,%0d) required=(%0d,%0d)",
                             pix_x, pix_y, e[19:10], e[9:0]);
                end
            end
        end
    end

    task automatic push_pix(input int x, input int y);
        logic [9:0] xx, yy;
        xx = 10'(x);
        yy = 10'(y);
        exp_q.push_back({xx, yy});
    endtask

    // Independent Bresenham reference used for the boundary and random segments.
    task automatic model_seg(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y, guard;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        guard = 0;
        while (guard < 2000) begin
            push_pix(x, y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            guard++;
        end
    endtask

    task automatic send_pen(input int x, input int y, input logic d);
        int n;
        n = 0;
        while (pen_ready !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (pen_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL pen_ready_timeout got=%b required=1", pen_ready);
        end
        pen_x     = 10'(x);
        pen_y     = 10'(y);
        pen_down  = d;
        pen_valid = 1'b1;
        @(posedge clk); #1;
        pen_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL segment_done busy=%b left=%0d required busy=0 left=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({pen_ready, pix_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_flags got pen_ready/pix_valid/busy=%b%b%b required=100",
                     pen_ready, pix_valid, busy);
        end
        total++;
        if ({pix_x, pix_y} !== 20'd0) begin
            bad++;
            $display("FAIL reset_pix got=(%0d,%0d) required=(0,0)", pix_x, pix_y);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_point();
        pix_ready = 1'b1;
        send_pen(100, 100, 1'b1);
        repeat (3) begin
            total++;
            if (pix_valid !== 1'b0 || pen_ready !== 1'b1) begin
                bad++;
                $display("FAIL first_point got pix_valid=%b pen_ready=%b required 0/1", pix_valid, pen_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_diag();
        push_pix(100, 100); push_pix(101, 101); push_pix(102, 101);
        push_pix(103, 102); push_pix(104, 102);
        pix_ready = 1'b1;
        send_pen(104, 102, 1'b1);
        total++;
        if (pix_valid !== 1'b0 || busy !== 1'b1 || pen_ready !== 1'b0) begin
            bad++;
            $display("FAIL diag_setup got pix_valid=%b busy=%b pen_ready=%b required 0/1/0",
                     pix_valid, busy, pen_ready);
        end
        @(posedge clk); #1;
        total++;
        if (pix_valid !== 1'b1 || {pix_x, pix_y} !== {10'd100, 10'd100}) begin
            bad++;
            $display("FAIL diag_latency got valid=%b (%0d,%0d) required valid=1 (100,100)",
                     pix_valid, pix_x, pix_y);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0 || pen_ready !== 1'b1) begin
            bad++;
            $display("FAIL diag_throughput got left=%0d busy=%b pen_ready=%b required 0/0/1",
                     exp_q.size(), busy, pen_ready);
        end
        wait_done(50);
    endtask

    task automatic test_stall();
        pix_ready = 1'b1;
        send_pen(10, 10, 1'b0);
        push_pix(10, 10); push_pix(10, 9); push_pix(10, 8); push_pix(10, 7);
        send_pen(10, 7, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (pix_valid !== 1'b1 || {pix_x, pix_y} !== {10'd10, 10'd9}) begin
                bad++;
                $display("FAIL stall_hold got valid=%b (%0d,%0d) required valid=1 (10,9)",
                         pix_valid, pix_x, pix_y);
            end
        end
        pix_ready = 1'b1;
        wait_done(50);
    endtask

    task automatic test_move();
        pix_ready = 1'b1;
        send_pen(50, 50, 1'b0);
        push_pix(50, 50); push_pix(51, 50); push_pix(52, 50);
        send_pen(52, 50, 1'b1);
        wait_done(50);
    endtask

    task automatic test_out_of_range();
        pix_ready = 1'b1;
        send_pen(700, 20, 1'b1);
        send_pen(30, 30, 1'b1);
        repeat (4) begin
            total++;
            if (pix_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL out_of_range got pix_valid=%b busy=%b required 0/0", pix_valid, busy);
            end
            @(posedge clk); #1;
        end
        push_pix(30, 30); push_pix(31, 30);
        send_pen(31, 30, 1'b1);
        wait_done(50);
    endtask

    task automatic test_reset_mid();
        pix_ready = 1'b1;
        send_pen(0, 0, 1'b0);
        model_seg(0, 0, 20, 0);
        send_pen(20, 0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        total++;
        if (pix_valid !== 1'b0 || pen_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got pix_valid=%b pen_ready=%b busy=%b required 0/1/0",
                     pix_valid, pen_ready, busy);
        end
        send_pen(5, 5, 1'b1);
        repeat (4) begin
            total++;
            if (pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_no_last got pix_valid=%b required 0", pix_valid);
            end
            @(posedge clk); #1;
        end
        model_x = 5;
        model_y = 5;
    endtask

    task automatic test_corner();
        pix_ready = 1'b1;
        send_pen(639, 479, 1'b0);
        model_seg(639, 479, 636, 477);
        send_pen(636, 477, 1'b1);
        wait_done(50);
        push_pix(636, 477);
        send_pen(636, 477, 1'b1);
        wait_done(50);
        send_pen(0, 479, 1'b0);
        model_seg(0, 479, 3, 470);
        send_pen(3, 470, 1'b1);
        wait_done(50);
        model_x = 3;
        model_y = 470;
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 5; s++) begin
            int nx, ny, n;
            nx = int'($urandom_range(0, 639));
            ny = int'($urandom_range(0, 479));
            model_seg(model_x, model_y, nx, ny);
            send_pen(nx, ny, 1'b1);
            n = 0;
            while ((busy !== 1'b0 || exp_q.size() != 0) && n < 4000) begin
                pix_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            total++;
            if (busy !== 1'b0 || exp_q.size() != 0) begin
                bad++;
                $display("FAIL back_to_back seg=%0d busy=%b left=%0d required 0/0", s, busy, exp_q.size());
            end
            model_x = nx;
            model_y = ny;
        end
        pix_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        pen_valid = 1'b0;
        pen_x     = '0;
        pen_y     = '0;
        pen_down  = 1'b0;
        pix_ready = 1'b0;
        test_reset();
        test_first_point();
        test_diag();
        test_stall();
        test_move();
        test_out_of_range();
        test_reset_mid();
        test_corner();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
